// File: rtl/popcount_acc_neuron_pkg.sv
// Shared types and helpers for the popcount accumulator neuron.
// Purely declarative: no logic, no latency.
// Used by the top and delta stage; sat_add serves the POPACC_SATURATE_EN build.
package popacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // pos - neg with both in 0..3 spans -3..+3, so three signed bits suffice.
  localparam int DELTA_W = 3;

  // Signed add clamped to the range of an acc_w-bit two's-complement value.
  // Operands are pre-sign-extended to 32 bits so the raw sum never wraps.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] delta,
                                                 input int acc_w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = acc + delta;
    hi  = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/popcount_acc_neuron_if.sv
// Beat-in / result-out bundle for the popcount accumulator neuron.
// No logic; master drives beats and out_ready, slave is the neuron.
// Both directions use valid/ready handshakes.
interface popcount_acc_neuron_if #(
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_pos;
  logic [1:0]       in_neg;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_act;
  logic [ACC_W-1:0] out_sum;
  logic             out_overrun;

  modport master (
    output in_valid, in_pos, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_overrun
  );

  modport slave (
    input  in_valid, in_pos, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_overrun
  );
endinterface

// File: rtl/popcount_acc_neuron_delta.sv
// Signed difference of two 2-bit popcounts (pos - neg), range -3..+3.
// Combinational, zero latency.
// No handshake; kept separate so an approximate subtractor can drop in here.
module popacc_delta
  import popacc_pkg::*;
(
  input  logic [1:0]                i_pos,
  input  logic [1:0]                i_neg,
  output logic signed [DELTA_W-1:0] o_delta
);

  assign o_delta = $signed({1'b0, i_pos}) - $signed({1'b0, i_neg});

endmodule

// File: rtl/popcount_acc_neuron.sv
// Accumulates (pos - neg) per beat until in_last or MAX_BEATS, then thresholds the sum.
// Result valid one cycle after the terminating beat; one result per N+1 cycles.
// in_ready drops while a result is held; define POPACC_SATURATE_EN to clamp instead of wrap.
module popcount_acc_neuron
  import popacc_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int THRESH    = 0,
  parameter int MAX_BEATS = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  popcount_acc_neuron_if.slave bus
);

  localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
  localparam logic [7:0]              MAX_V    = 8'(MAX_BEATS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_out_sum;
  logic                      r_out_act;
  logic                      r_out_overrun;
  logic [7:0]                r_beat_cnt;
  logic [7:0]                w_cnt_nxt;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   w_next;
  logic signed [DELTA_W-1:0] w_delta;
  logic                      w_in_rdy;
  logic                      w_hs;
  logic                      w_term;

  popacc_delta u_delta (
    .i_pos   (bus.in_pos),
    .i_neg   (bus.in_neg),
    .o_delta (w_delta)
  );

  assign w_in_rdy = (r_state != OUT);
  assign w_hs     = bus.in_valid & w_in_rdy;

  // A fresh evaluation starts from zero regardless of leftover acc contents.
  assign w_base    = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_nxt = ((r_state == IDLE) ? 8'd0 : r_beat_cnt) + 8'd1;

`ifdef POPACC_SATURATE_EN
  assign w_next = ACC_W'(sat_add(32'(w_base), 32'(w_delta), ACC_W));
`else
  logic signed [ACC_W-1:0] w_delta_ext;
  assign w_delta_ext = {{(ACC_W-DELTA_W){w_delta[DELTA_W-1]}}, w_delta};
  assign w_next      = w_base + w_delta_ext;
`endif

  assign w_term = w_hs & (bus.in_last | (w_cnt_nxt == MAX_V));

  // Next-state: accept beats until termination, hold the result until drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACC: begin
        if (w_term) begin
          w_state_nxt = OUT;
        end else if (w_hs) begin
          w_state_nxt = ACC;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, beat counter and result registers; results persist after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_beat_cnt    <= '0;
      r_out_sum     <= '0;
      r_out_act     <= 1'b0;
      r_out_overrun <= 1'b0;
    end else if (r_state == OUT) begin
      if (bus.out_ready) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
      end
    end else if (w_hs) begin
      r_acc      <= w_next;
      r_beat_cnt <= w_cnt_nxt;
      if (w_term) begin
        r_out_sum     <= w_next;
        r_out_act     <= (w_next >= THRESH_V);
        r_out_overrun <= ~bus.in_last;
      end
    end
  end

  assign bus.in_ready    = w_in_rdy;
  assign bus.out_valid   = (r_state == OUT);
  assign bus.out_sum     = r_out_sum;
  assign bus.out_act     = r_out_act;
  assign bus.out_overrun = r_out_overrun;

endmodule

// File: tb/tb_popcount_acc_neuron.sv
// Directed bench for popcount_acc_neuron across three parameterisations.
// dut0: ACC_W=8/MAX 16, dut1: ACC_W=8/MAX 4, dut2: ACC_W=4/MAX 16.
// Expected values for dut2 follow POPACC_SATURATE_EN when it is defined.
module tb_popcount_acc_neuron;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  popcount_acc_neuron_if #(.ACC_W(8)) if0 ();
  popcount_acc_neuron_if #(.ACC_W(8)) if1 ();
  popcount_acc_neuron_if #(.ACC_W(4)) if2 ();

  popcount_acc_neuron #(.ACC_W(8), .THRESH(0), .MAX_BEATS(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  popcount_acc_neuron #(.ACC_W(8), .THRESH(0), .MAX_BEATS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  popcount_acc_neuron #(.ACC_W(4), .THRESH(0), .MAX_BEATS(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat to dut d for a single clock, then idle its input.
  task automatic beat(input int d, input logic [1:0] p, input logic [1:0] n, input logic l);
    case (d)
      0: begin if0.in_valid = 1'b1; if0.in_pos = p; if0.in_neg = n; if0.in_last = l; end
      1: begin if1.in_valid = 1'b1; if1.in_pos = p; if1.in_neg = n; if1.in_last = l; end
      default: begin if2.in_valid = 1'b1; if2.in_pos = p; if2.in_neg = n; if2.in_last = l; end
    endcase
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
    if1.in_valid = 1'b0; if1.in_last = 1'b0;
    if2.in_valid = 1'b0; if2.in_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_pos = 2'd0; if0.in_neg = 2'd0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_pos = 2'd0; if1.in_neg = 2'd0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_pos = 2'd0; if2.in_neg = 2'd0; if2.in_last = 1'b0; if2.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_out_sum", if0.out_sum, 0);
    check("rst_out_act", if0.out_act, 0);
    check("rst_out_overrun", if0.out_overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready0", if0.in_ready, 1);
    check("rst_in_ready2", if2.in_ready, 1);

    // Three beats (3,0),(2,1),(0,3,last) -> sum 1
    beat(0, 2'd3, 2'd0, 1'b0);
    beat(0, 2'd2, 2'd1, 1'b0);
    check("t1_no_early_valid", if0.out_valid, 0);
    beat(0, 2'd0, 2'd3, 1'b1);
    check("t1_valid", if0.out_valid, 1);
    check("t1_sum", if0.out_sum, 32'h01);
    check("t1_act", if0.out_act, 1);
    check("t1_overrun", if0.out_overrun, 0);
    tick();
    check("t1_drained", if0.out_valid, 0);
    check("t1_sum_held", if0.out_sum, 32'h01);

    // Single beat (0,2,last) -> -2
    beat(0, 2'd0, 2'd2, 1'b1);
    check("t2_in_ready_low", if0.in_ready, 0);
    check("t2_valid", if0.out_valid, 1);
    check("t2_sum", if0.out_sum, 32'hFE);
    check("t2_act", if0.out_act, 0);
    tick();
    check("t2_in_ready_back", if0.in_ready, 1);

    // Idle gap in ACC holds the partial sum; (3,3) contributes zero
    beat(0, 2'd2, 2'd0, 1'b0);
    repeat (3) begin
      tick();
      check("gap_no_valid", if0.out_valid, 0);
    end
    beat(0, 2'd3, 2'd3, 1'b1);
    check("gap_sum", if0.out_sum, 32'h02);
    check("gap_act", if0.out_act, 1);
    tick();

    // Backpressure: result held 5 cycles while in_valid toggles data
    if0.out_ready = 1'b0;
    beat(0, 2'd1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if0.in_pos   = 2'(i);
      if0.in_neg   = 2'(3 - i);
      if0.in_last  = 1'b1;
      tick();
      check("stall_in_ready", if0.in_ready, 0);
      check("stall_valid", if0.out_valid, 1);
      check("stall_sum", if0.out_sum, 32'h01);
    end
    if0.in_valid  = 1'b0;
    if0.in_last   = 1'b0;
    if0.out_ready = 1'b1;
    tick();
    check("stall_drained", if0.out_valid, 0);
    beat(0, 2'd0, 2'd1, 1'b1);
    check("stall_next_sum", if0.out_sum, 32'hFF);
    check("stall_next_act", if0.out_act, 0);
    tick();

    // MAX_BEATS=4 force-termination
    beat(1, 2'd1, 2'd0, 1'b0);
    beat(1, 2'd1, 2'd0, 1'b0);
    beat(1, 2'd1, 2'd0, 1'b0);
    check("max_no_valid_at3", if1.out_valid, 0);
    beat(1, 2'd1, 2'd0, 1'b0);
    check("max_valid", if1.out_valid, 1);
    check("max_sum", if1.out_sum, 32'h04);
    check("max_overrun", if1.out_overrun, 1);
    check("max_act", if1.out_act, 1);
    check("max_in_ready", if1.in_ready, 0);
    tick();
    // in_last on the 4th beat is a normal finish
    beat(1, 2'd1, 2'd0, 1'b0);
    beat(1, 2'd1, 2'd0, 1'b0);
    beat(1, 2'd1, 2'd0, 1'b0);
    beat(1, 2'd0, 2'd0, 1'b1);
    check("max_last_sum", if1.out_sum, 32'h03);
    check("max_last_overrun", if1.out_overrun, 0);
    tick();

    // ACC_W=4: five beats of +3
    repeat (4) beat(2, 2'd3, 2'd0, 1'b0);
    beat(2, 2'd3, 2'd0, 1'b1);
    check("w4_valid", if2.out_valid, 1);
`ifdef POPACC_SATURATE_EN
    check("w4_sum", if2.out_sum, 32'h7);
    check("w4_act", if2.out_act, 1);
`else
    check("w4_sum", if2.out_sum, 32'hF);
    check("w4_act", if2.out_act, 0);
`endif
    tick();
    // Clamp applies per beat only: +9 then -3
    repeat (3) beat(2, 2'd3, 2'd0, 1'b0);
    beat(2, 2'd0, 2'd3, 1'b1);
`ifdef POPACC_SATURATE_EN
    check("w4_back_sum", if2.out_sum, 32'h4);
`else
    check("w4_back_sum", if2.out_sum, 32'h6);
`endif
    check("w4_back_act", if2.out_act, 1);
    tick();
    // Negative side: -9
    repeat (3) beat(2, 2'd0, 2'd3, 1'b0);
    beat(2, 2'd0, 2'd0, 1'b1);
`ifdef POPACC_SATURATE_EN
    check("w4_neg_sum", if2.out_sum, 32'h8);
    check("w4_neg_act", if2.out_act, 0);
`else
    check("w4_neg_sum", if2.out_sum, 32'h7);
    check("w4_neg_act", if2.out_act, 1);
`endif
    tick();

    // Reset mid-ACC after two beats
    beat(0, 2'd3, 2'd0, 1'b0);
    beat(0, 2'd3, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", if0.out_sum, 0);
    check("mid_rst_valid", if0.out_valid, 0);
    check("mid_rst_w4_sum", if2.out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_in_ready", if0.in_ready, 1);
    beat(0, 2'd1, 2'd0, 1'b1);
    check("mid_rst_next_sum", if0.out_sum, 32'h01);
    check("mid_rst_next_act", if0.out_act, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
